// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host byte link and instruction-memory write port of the program loader
interface program_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8
);
  logic                      start;
  logic [DATA_WIDTH-1:0]     byte_in;
  logic                      byte_valid;
  logic                      byte_ready;
  logic                      we;
  logic [ADDRESS_WIDTH-1:0]  wa;
  logic [4*DATA_WIDTH-1:0]   wd;
  logic                      busy;
  logic                      done;
  logic                      error;

  // Host / testbench side: drives the byte stream and start, observes everything else.
  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, we, wa, wd, busy, done, error
  );

  // Loader side.
  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, we, wa, wd, busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time loader packing a length-prefixed byte stream into word writes
module program_loader #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       MAX_BYTES     = 4096
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);
  localparam int WORD_W = 4 * DATA_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]               state;
  logic [1:0]               hdr_cnt;
  logic [WORD_W-1:0]        len;
  logic [WORD_W-1:0]        count;
  logic [WORD_W-1:0]        pack;
  logic [ADDRESS_WIDTH-1:0] word_idx;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] wa_q;
  logic [WORD_W-1:0]        wd_q;

  logic                     accept;
  logic [WORD_W-1:0]        len_next;
  logic [WORD_W-1:0]        count_inc;
  logic [WORD_W-1:0]        pack_next;

  assign bus.byte_ready = (state == S_HDR) || (state == S_DATA);
  assign bus.busy       = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE);
  assign bus.done       = (state == S_DONE);
  assign bus.error      = (state == S_ERROR);
  assign bus.we         = we_q;
  assign bus.wa         = wa_q;
  assign bus.wd         = wd_q;

  assign accept    = bus.byte_valid && bus.byte_ready;
  // Header bytes shift in from the top so the first byte ends up in len[7:0].
  assign len_next  = {bus.byte_in, len[WORD_W-1:DATA_WIDTH]};
  assign count_inc = count + WORD_W'(1);

  // Drop the incoming byte into its lane; lanes above it are still zero from the last clear.
  always_comb begin
    pack_next = pack;
    pack_next[count[1:0]*DATA_WIDTH +: DATA_WIDTH] = bus.byte_in;
  end

  // Load sequencer: header capture, byte packing and the one-cycle word write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hdr_cnt  <= '0;
      len      <= '0;
      count    <= '0;
      pack     <= '0;
      word_idx <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state    <= S_HDR;
            hdr_cnt  <= '0;
            count    <= '0;
            word_idx <= '0;
            pack     <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            len     <= len_next;
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              if (len_next == '0)
                state <= S_DONE;
              else if (len_next > WORD_W'(MAX_BYTES))
                state <= S_ERROR;
              else
                state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            pack  <= pack_next;
            count <= count_inc;
            // Registered write outputs are loaded here so we rises together with WRITE.
            if ((count[1:0] == 2'd3) || (count_inc == len)) begin
              state <= S_WRITE;
              we_q  <= 1'b1;
              wa_q  <= BASE_ADDR + (word_idx << 2);
              wd_q  <= pack_next;
            end
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + ADDRESS_WIDTH'(1);
          pack     <= '0;
          state    <= (count == len) ? S_DONE : S_DATA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  program_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) bus ();

  program_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (8),
    .BASE_ADDR    (32'h0),
    .MAX_BYTES    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wa_log.push_back(bus.wa);
      wd_log.push_back(bus.wd);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.byte_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("byte_accept_timeout", (t < 50), 1'b1);
    @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int max_gap, input bit inject_start);
    for (int i = 0; i < q.size(); i++) begin
      if (inject_start && (i % 3 == 1)) pulse_start();
      send_byte(q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (bus.done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, (t < 100), 1'b1);
  endtask

  initial begin
    logic [7:0] q[$];
    int n0;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.byte_in   = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ready", bus.byte_ready, 1'b0);
    check("rst_we",    bus.we,         1'b0);
    check("rst_busy",  bus.busy,       1'b0);
    check("rst_done",  bus.done,       1'b0);
    check("rst_error", bus.error,      1'b0);
    check("rst_wa",    bus.wa,         32'h0);
    check("rst_wd",    bus.wd,         32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Eight bytes, valid held high throughout.
    n0 = wa_log.size();
    pulse_start();
    check("A_busy", bus.busy, 1'b1);
    q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_stream(q, 0, 1'b0);
    wait_done("A_done_timeout");
    check("A_nwr",  wa_log.size() - n0, 2);
    check("A_wa0",  wa_log[n0],         32'h0);
    check("A_wd0",  wd_log[n0],         32'h0000_0013);
    check("A_wa1",  wa_log[n0+1],       32'h4);
    check("A_wd1",  wd_log[n0+1],       32'h0010_0093);
    check("A_done", bus.done,           1'b1);
    check("A_busy_end", bus.busy,       1'b0);

    // Five bytes: final partial word zero-filled.
    n0 = wa_log.size();
    pulse_start();
    check("B_done_clr", bus.done, 1'b0);
    q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_stream(q, 0, 1'b0);
    wait_done("B_done_timeout");
    check("B_nwr", wa_log.size() - n0, 2);
    check("B_wa0", wa_log[n0],         32'h0);
    check("B_wd0", wd_log[n0],         32'hDDCC_BBAA);
    check("B_wa1", wa_log[n0+1],       32'h4);
    check("B_wd1", wd_log[n0+1],       32'h0000_00EE);

    // Zero length: done on the cycle right after the last header byte.
    n0 = wa_log.size();
    pulse_start();
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(q, 0, 1'b0);
    check("Z_done", bus.done, 1'b1);
    check("Z_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    check("Z_nwr", wa_log.size() - n0, 0);

    // Length 32 exceeds MAX_BYTES=16.
    n0 = wa_log.size();
    pulse_start();
    q = '{8'h20, 8'h00, 8'h00, 8'h00};
    send_stream(q, 0, 1'b0);
    check("E_error", bus.error,      1'b1);
    check("E_ready", bus.byte_ready, 1'b0);
    check("E_done",  bus.done,       1'b0);
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("E_nwr",   wa_log.size() - n0, 0);
    check("E_still_error", bus.error, 1'b1);
    pulse_start();
    check("E_restart_busy",  bus.busy,  1'b1);
    check("E_restart_error", bus.error, 1'b0);

    // Length exactly MAX_BYTES is accepted (continues from the HDR just entered).
    q = '{8'h10, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
          8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    send_stream(q, 0, 1'b0);
    wait_done("M_done_timeout");
    check("M_nwr", wa_log.size() - n0, 4);
    check("M_wd0", wd_log[n0],   32'h0302_0100);
    check("M_wa3", wa_log[n0+3], 32'hC);
    check("M_wd3", wd_log[n0+3], 32'h0F0E_0D0C);

    // Reset after 6 of 8 payload bytes: abandon, then reload cleanly.
    n0 = wa_log.size();
    pulse_start();
    q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_stream(q, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("R_busy",  bus.busy,       1'b0);
    check("R_ready", bus.byte_ready, 1'b0);
    check("R_we",    bus.we,         1'b0);
    check("R_wa",    bus.wa,         32'h0);
    check("R_wd",    bus.wd,         32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("R_nwr_abandon", wa_log.size() - n0, 1);
    n0 = wa_log.size();
    pulse_start();
    q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_stream(q, 0, 1'b0);
    wait_done("R_done_timeout");
    check("R_nwr", wa_log.size() - n0, 2);
    check("R_wa0", wa_log[n0],   32'h0);
    check("R_wd0", wd_log[n0],   32'h0000_0013);
    check("R_wa1", wa_log[n0+1], 32'h4);
    check("R_wd1", wd_log[n0+1], 32'h0010_0093);

    // Random valid gaps and stray start pulses while busy: same writes as the gap-free run.
    n0 = wa_log.size();
    pulse_start();
    send_stream(q, 3, 1'b1);
    wait_done("G_done_timeout");
    check("G_nwr", wa_log.size() - n0, 2);
    check("G_wa0", wa_log[n0],   32'h0);
    check("G_wd0", wd_log[n0],   32'h0000_0013);
    check("G_wa1", wa_log[n0+1], 32'h4);
    check("G_wd1", wd_log[n0+1], 32'h0010_0093);
    check("G_error", bus.error,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory.
- Accepts a byte stream: a 4-byte little-endian length header, then the program bytes.
- Packs the bytes into 32-bit little-endian words and issues one single-cycle word write per word, at consecutive byte addresses from BASE_ADDR.
- Sits between the host byte link and the instruction memory's write port. The core is held off via busy until the load completes.

Parameters:
- ADDRESS_WIDTH, 32, width of the byte address driven on wa.
- DATA_WIDTH, 8, width of one stream byte; the word is 4*DATA_WIDTH.
- BASE_ADDR, 0, byte address of the first written word; must be 4-aligned.
- MAX_BYTES, 4096, largest accepted payload length in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_in  input  DATA_WIDTH  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte; a transfer occurs when byte_valid&&byte_ready.
- we  output  1  word write enable, one cycle per word.
- wa  output  ADDRESS_WIDTH  byte address of the word being written.
- wd  output  4*DATA_WIDTH  word data; byte at wa is wd[7:0], byte at wa+3 is wd[31:24].
- busy  output  1  high in HDR, DATA and WRITE.
- done  output  1  sticky; high in DONE.
- error  output  1  sticky; high in ERROR.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - byte_ready, we, busy, done and error all 0; wa = 0; wd = 0.
  - Internal length, byte count, word index and packing register all cleared.
  - A partially written program is abandoned; no further write is issued.
- States: IDLE, HDR, DATA, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR: start=1 → HDR next cycle; byte count, word index and packing register cleared; done and error cleared.
- start is ignored in HDR, DATA and WRITE.
- HDR:
  - byte_ready=1. Four accepted bytes form len, little-endian (first byte = len[7:0]).
  - On the 4th accepted byte:
    - len==0 → DONE.
    - len>MAX_BYTES → ERROR.
    - otherwise → DATA.
- DATA:
  - byte_ready=1. Each accepted byte is placed at lane (count mod 4) of the packing register; count increments.
  - When lane 3 is filled, or the accepted byte is the last (count reaches len) → WRITE.
  - A final partial word has unfilled upper lanes = 0.
- WRITE (exactly one cycle):
  - byte_ready=0, we=1, wa=BASE_ADDR+4*word_idx, wd=packing register.
  - Next cycle: word_idx increments and the packing register clears.
  - Next state is DONE if count==len, else DATA.
  - Effective throughput: 4 bytes per 5 cycles at best.
- we, wa and wd are registered, with zero latency relative to the WRITE state: we is high during the cycle the state register holds WRITE.
- wa and wd hold their last values when we=0.
- byte_valid while byte_ready=0 is not consumed; the byte is held by the source (no drop, no duplicate).
- Bytes arriving in IDLE, DONE or ERROR are never accepted.
- Address arithmetic is modulo 2**ADDRESS_WIDTH, with no wrap check.
- busy=1 exactly in HDR, DATA and WRITE.

Test Plan:
- Reset mid-DATA after 6 of 8 payload bytes → next cycle all outputs 0 with no we pulse; a new start plus a full stream loads correctly from BASE_ADDR.
- start, then header 08 00 00 00, payload 13 00 00 00 93 00 10 00 with byte_valid held high → two we pulses:
  - wa=0, wd=0x00000013;
  - wa=4, wd=0x00100093;
  - then done=1, busy=0.
- Header 05 00 00 00, payload AA BB CC DD EE → writes 0xDDCCBBAA@0, then 0x000000EE@4; done=1.
- Header 00 00 00 00 → no we; done=1 the cycle after the 4th header byte.
- MAX_BYTES=16, header 20 00 00 00 → error=1, byte_ready=0, no we. A later start returns to HDR with error=0.
- Random byte_valid gaps, start pulses during busy, and valid asserted during WRITE → identical write sequence to the gap-free run, with the start pulses ignored.
